// File: rtl/bp_stream_arbiter.sv
// Locking round-robin arbiter that merges several multi-beat streaming requesters
// onto one stream port; a message keeps the port from its first beat through its last.
module bp_stream_arbiter #(
    parameter int num_req_p      = 2,
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int max_beats_p    = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [num_req_p*header_width_p-1:0]  req_header_i,
    input  logic [num_req_p*data_width_p-1:0]    req_data_i,
    input  logic [num_req_p-1:0]                 req_v_i,
    input  logic [num_req_p-1:0]                 req_last_i,
    output logic [num_req_p-1:0]                 req_ready_and_o,
    output logic [header_width_p-1:0]            mem_header_o,
    output logic [data_width_p-1:0]              mem_data_o,
    output logic                                 mem_v_o,
    output logic                                 mem_last_o,
    input  logic                                 mem_ready_and_i,
    output logic [num_req_p-1:0]                 grant_o,
    output logic                                 error_o
);

    localparam int PTR_W = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int CNT_W = $clog2(max_beats_p + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(num_req_p - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_beats_p);
    localparam logic [CNT_W-1:0] CNT_ERR = CNT_W'(max_beats_p - 1);

    logic [0:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;

    logic             win_v;
    logic [PTR_W-1:0] win_id;
    logic [PTR_W-1:0] cand;
    logic             accept;

    // Descending scan so the candidate closest to ptr_q is the last one written.
    always_comb begin
        win_v  = 1'b0;
        win_id = '0;
        cand   = '0;
        if (state_q == LOCKED) begin
            win_id = lock_q;
            win_v  = req_v_i[lock_q];
        end else begin
            for (int i = num_req_p - 1; i >= 0; i--) begin
                cand = PTR_W'((int'(ptr_q) + i) % num_req_p);
                if (req_v_i[cand]) begin
                    win_v  = 1'b1;
                    win_id = cand;
                end
            end
        end
    end

    always_comb begin
        grant_o         = '0;
        req_ready_and_o = '0;
        mem_v_o         = win_v;
        mem_header_o    = req_header_i[int'(win_id)*header_width_p +: header_width_p];
        mem_data_o      = req_data_i[int'(win_id)*data_width_p +: data_width_p];
        mem_last_o      = win_v & req_last_i[win_id];
        if (win_v) begin
            grant_o[win_id]         = 1'b1;
            // Gating with reset_i keeps requesters from seeing a handshake during reset.
            req_ready_and_o[win_id] = mem_ready_and_i & reset_i;
        end
    end

    assign accept  = win_v & mem_ready_and_i;
    assign error_o = error_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        if (accept) begin
            if (mem_last_o) begin
                state_d = IDLE;
                ptr_d   = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
                cnt_d   = '0;
            end else begin
                state_d = LOCKED;
                lock_d  = win_id;
                if (cnt_q == CNT_ERR) begin
                    error_d = 1'b1;
                end
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_bp_stream_arbiter.sv
// Scoreboard bench for bp_stream_arbiter: producers drain per-requester beat queues,
// a negedge monitor checks every delivered beat and the port invariants.
module tb_bp_stream_arbiter;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          gap;
    } beat_t;

    logic        clk;
    logic        reset_i;
    logic [63:0] req_header_i;
    logic [127:0] req_data_i;
    logic [1:0]  req_v_i;
    logic [1:0]  req_last_i;
    logic [1:0]  req_ready_and_o;
    logic [31:0] mem_header_o;
    logic [63:0] mem_data_o;
    logic        mem_v_o;
    logic        mem_last_o;
    logic        mem_ready_and_i;
    logic [1:0]  grant_o;
    logic        error_o;

    beat_t cmd_q[2][$];
    beat_t exp_q[2][$];
    int    ord_q[$];

    int    n_cmp = 0;
    int    n_fail = 0;
    int    seq = 0;
    int    tmo_cnt = 0;
    int    tmo_seen = 0;
    string tmo_name = "";
    logic  rdy_mode = 1'b0;

    bp_stream_arbiter #(
        .num_req_p(2), .header_width_p(32), .data_width_p(64), .max_beats_p(8)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_header_i(req_header_i), .req_data_i(req_data_i),
        .req_v_i(req_v_i), .req_last_i(req_last_i),
        .req_ready_and_o(req_ready_and_o),
        .mem_header_o(mem_header_o), .mem_data_o(mem_data_o),
        .mem_v_o(mem_v_o), .mem_last_o(mem_last_o),
        .mem_ready_and_i(mem_ready_and_i),
        .grant_o(grant_o), .error_o(error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] hdr_of(input logic [63:0] d);
        return d[31:0] ^ 32'hA5A5_0000 ^ {d[63:56], 24'h0};
    endfunction

    initial begin
        mem_ready_and_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            mem_ready_and_i = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // One producer per requester: holds each beat until it is handshaken.
    for (genvar k = 0; k < 2; k++) begin : g_prod
        logic        v, l, fired, loaded;
        logic [63:0] d;
        int          gap;
        beat_t       cur;

        assign req_v_i[k]                = v;
        assign req_last_i[k]             = l;
        assign req_data_i[k*64 +: 64]    = d;
        assign req_header_i[k*32 +: 32]  = hdr_of(d);

        initial begin
            fired = 1'b0;
            forever begin
                @(negedge clk);
                fired = v & req_ready_and_o[k];
            end
        end

        initial begin
            v = 1'b0; l = 1'b0; d = '0; loaded = 1'b0; gap = 0;
            cur.data = '0; cur.last = 1'b0; cur.gap = 0;
            forever begin
                @(posedge clk); #1;
                if (loaded && v && fired) begin
                    loaded = 1'b0;
                    v = 1'b0;
                end
                if (!loaded && cmd_q[k].size() > 0) begin
                    cur = cmd_q[k].pop_front();
                    loaded = 1'b1;
                    gap = cur.gap;
                end
                if (loaded) begin
                    if (gap > 0) begin
                        gap--;
                        v = 1'b0;
                    end else begin
                        v = 1'b1;
                        d = cur.data;
                        l = cur.last;
                    end
                end
            end
        end
    end

    // Monitor
    initial begin : monitor
        int    owner, cur_owner, cnt_m, o;
        logic  in_msg, err_exp;
        beat_t e;
        in_msg = 1'b0; err_exp = 1'b0; cnt_m = 0; cur_owner = 0;
        forever begin
            @(negedge clk);
            if (tmo_cnt != tmo_seen) begin
                n_cmp++; n_fail++;
                $display("FAIL timeout_%s: beats still pending, required all delivered", tmo_name);
                tmo_seen = tmo_cnt;
            end
            if (!reset_i) begin
                chk("rst_error", 64'(error_o), 64'd0);
                chk("rst_ready", 64'(req_ready_and_o), 64'd0);
                if (!mem_v_o) chk("rst_grant", 64'(grant_o), 64'd0);
                in_msg = 1'b0; cnt_m = 0; err_exp = 1'b0;
            end else begin
                chk("error_flag", 64'(error_o), 64'(err_exp));
                chk("ready_and", 64'(req_ready_and_o),
                    64'(mem_ready_and_i ? grant_o : 2'b00));
                if (!mem_v_o) chk("grant_idle", 64'(grant_o), 64'd0);
                else          chk("grant_onehot", 64'($onehot(grant_o)), 64'd1);
                if (mem_v_o && mem_ready_and_i) begin
                    owner = grant_o[1] ? 1 : 0;
                    if (ord_q.size() > 0) begin
                        o = ord_q.pop_front();
                        chk("order", 64'(owner), 64'(o));
                    end
                    if (in_msg) chk("no_interleave", 64'(owner), 64'(cur_owner));
                    if (exp_q[owner].size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL extra_beat: req%0d data %h, required no beat", owner, mem_data_o);
                    end else begin
                        e = exp_q[owner].pop_front();
                        chk("beat_data", mem_data_o, e.data);
                        chk("beat_header", 64'(mem_header_o), 64'(hdr_of(e.data)));
                        chk("beat_last", 64'(mem_last_o), 64'(e.last));
                    end
                    if (mem_last_o) begin
                        in_msg = 1'b0;
                        cnt_m = 0;
                    end else begin
                        in_msg = 1'b1;
                        cur_owner = owner;
                        if (cnt_m == 7) err_exp = 1'b1;
                        if (cnt_m < 8) cnt_m++;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_beat(input int k, input logic lst, input int gap);
        beat_t b;
        b.data = {8'(k), 24'h0, 32'(seq)};
        b.last = lst;
        b.gap  = gap;
        seq++;
        cmd_q[k].push_back(b);
        exp_q[k].push_back(b);
    endtask

    task automatic wait_drain(input string nm, input int maxc);
        int c;
        c = 0;
        while ((exp_q[0].size() + exp_q[1].size() + ord_q.size()) != 0 && c < maxc) begin
            @(posedge clk); #2;
            c++;
        end
        if ((exp_q[0].size() + exp_q[1].size() + ord_q.size()) != 0) begin
            tmo_name = nm;
            tmo_cnt++;
            exp_q[0].delete(); exp_q[1].delete(); ord_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin : main
        int c;
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        reset_i = 1'b1;
        @(negedge clk);

        // Alternating single-beat messages: 0,1,0,1
        push_beat(0, 1'b1, 0); push_beat(0, 1'b1, 0);
        push_beat(1, 1'b1, 0); push_beat(1, 1'b1, 0);
        ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(0); ord_q.push_back(1);
        wait_drain("alternate", 100);

        // Four-beat message from req0 keeps the port while req1 waits
        for (int i = 0; i < 4; i++) push_beat(0, i == 3, 0);
        push_beat(1, 1'b1, 0);
        for (int i = 0; i < 4; i++) ord_q.push_back(0);
        ord_q.push_back(1);
        wait_drain("lock4", 100);

        // req0 drops valid for 3 cycles mid-message; port must stall, not switch
        push_beat(0, 1'b0, 0); push_beat(0, 1'b0, 3);
        push_beat(0, 1'b0, 0); push_beat(0, 1'b1, 0);
        push_beat(1, 1'b1, 0);
        for (int i = 0; i < 4; i++) ord_q.push_back(0);
        ord_q.push_back(1);
        wait_drain("stall", 100);

        // Overlong message: error rises on the 8th accepted beat and sticks
        for (int i = 0; i < 9; i++) push_beat(0, 1'b0, 0);
        push_beat(0, 1'b1, 0);
        wait_drain("overlong", 100);

        // Reset during beat 2 of a req1 message abandons the lock
        for (int i = 0; i < 3; i++) push_beat(1, i == 2, 0);
        ord_q.push_back(1);
        c = 0;
        while (exp_q[1].size() != 2 && c < 50) begin
            @(posedge clk); #2;
            c++;
        end
        if (exp_q[1].size() != 2) begin
            tmo_name = "reset_sync";
            tmo_cnt++;
        end
        reset_i = 1'b0;
        push_beat(0, 1'b1, 0);
        ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(1);
        repeat (2) begin
            @(posedge clk); #2;
        end
        reset_i = 1'b1;
        wait_drain("reset_mid", 100);

        // Random traffic with random backpressure
        @(negedge clk);
        rdy_mode = 1'b1;
        for (int m = 0; m < 200; m++) begin
            int k, len;
            k   = $urandom_range(0, 1);
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) push_beat(k, b == len - 1, $urandom_range(0, 2));
        end
        wait_drain("random", 30000);
        rdy_mode = 1'b0;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
